// File: rtl/ff_stream_checker.sv
// ff_stream_checker
// Receiver that sits beside a positive-edge DFF under test. It samples the
// stimulus bit d and the DFF output q_ff on every rising edge, and checks
// that q_ff equals d delayed by one cycle. It also counts rising and falling
// edges of d and flags a programmed serial pattern.
//
// A CHECK or PRIME edge taken with en low only leaves for IDLE. That edge does
// no counting, comparing or shifting, so the counters are held across the exit.
module ff_stream_checker #(
    parameter int               CNT_W       = 8,
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] PATTERN     = 4'b1010,
    parameter bit               STOP_ON_ERR = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             d,
    input  logic             q_ff,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err,
    output logic             pat_hit,
    output logic [1:0]       state
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_CHECK = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_d_q;
    logic [PAT_W-1:0]   r_shift;
    logic [FILL_W-1:0]  r_fill;
    logic [CNT_W-1:0]   r_rise;
    logic [CNT_W-1:0]   r_fall;
    logic [CNT_W-1:0]   r_errc;
    logic               r_err;
    logic               r_hit;

    logic               w_mismatch;
    logic [CNT_W-1:0]   w_rise_next;
    logic [CNT_W-1:0]   w_fall_next;
    logic [PAT_W-1:0]   w_shift_next;
    logic [FILL_W-1:0]  w_fill_next;
    logic               w_pat_match;

    // Unsigned increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Next-value logic shared by the PRIME and CHECK states.
    always_comb begin
        w_mismatch   = q_ff ^ r_d_q;
        w_shift_next = {r_shift[PAT_W-2:0], d};
        if ((d == 1'b1) && (r_d_q == 1'b0)) begin
            w_rise_next = sat_inc(r_rise);
        end else begin
            w_rise_next = r_rise;
        end
        if ((d == 1'b0) && (r_d_q == 1'b1)) begin
            w_fall_next = sat_inc(r_fall);
        end else begin
            w_fall_next = r_fall;
        end
        if (r_fill == FILL_FULL) begin
            w_fill_next = r_fill;
        end else begin
            w_fill_next = r_fill + {{(FILL_W-1){1'b0}}, 1'b1};
        end
        w_pat_match = (w_fill_next == FILL_FULL) && (w_shift_next == PATTERN);
    end

    // Checker FSM with all counters, flags and history registered.
    always_ff @(posedge clk) begin
        if ((rst_n == 1'b0) || (clr == 1'b1)) begin
            r_state <= ST_IDLE;
            r_d_q   <= 1'b0;
            r_shift <= {PAT_W{1'b0}};
            r_fill  <= {FILL_W{1'b0}};
            r_rise  <= {CNT_W{1'b0}};
            r_fall  <= {CNT_W{1'b0}};
            r_errc  <= {CNT_W{1'b0}};
            r_err   <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // History stays empty so a re-enable cannot match stale bits.
                    r_d_q   <= d;
                    r_shift <= {PAT_W{1'b0}};
                    r_fill  <= {FILL_W{1'b0}};
                    r_hit   <= 1'b0;
                    if (en == 1'b1) begin
                        r_state <= ST_PRIME;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PRIME: begin
                    // DUT history is unknown here, so count and shift but do not compare.
                    r_d_q <= d;
                    if (en == 1'b1) begin
                        r_rise  <= w_rise_next;
                        r_fall  <= w_fall_next;
                        r_shift <= w_shift_next;
                        r_fill  <= w_fill_next;
                        r_hit   <= w_pat_match;
                        r_state <= ST_CHECK;
                    end else begin
                        r_shift <= {PAT_W{1'b0}};
                        r_fill  <= {FILL_W{1'b0}};
                        r_hit   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    r_d_q <= d;
                    if (en == 1'b1) begin
                        r_rise  <= w_rise_next;
                        r_fall  <= w_fall_next;
                        r_shift <= w_shift_next;
                        r_fill  <= w_fill_next;
                        r_hit   <= w_pat_match;
                        if (w_mismatch == 1'b1) begin
                            r_errc <= sat_inc(r_errc);
                            r_err  <= 1'b1;
                            if (STOP_ON_ERR != 1'b0) begin
                                r_state <= ST_FAIL;
                            end else begin
                                r_state <= ST_CHECK;
                            end
                        end else begin
                            r_state <= ST_CHECK;
                        end
                    end else begin
                        r_shift <= {PAT_W{1'b0}};
                        r_fill  <= {FILL_W{1'b0}};
                        r_hit   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_FAIL: begin
                    // Frozen until clr or rst_n; en has no effect.
                    r_hit   <= 1'b0;
                    r_state <= ST_FAIL;
                end
                default: begin
                    r_hit   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rise_cnt = r_rise;
    assign fall_cnt = r_fall;
    assign err_cnt  = r_errc;
    assign err      = r_err;
    assign pat_hit  = r_hit;
    assign state    = r_state;

endmodule

// File: tb/tb_ff_stream_checker.sv
// Bench for ff_stream_checker: three instances (default, STOP_ON_ERR=0,
// CNT_W=2), each fed by its own reference DFF whose output can be inverted
// for one cycle to plant a fault. Directed steps push hand-computed
// expectations; a monitor pops one per cycle and compares.
module tb_ff_stream_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n_v = 3'b000;
    logic [2:0] en_v    = 3'b000;
    logic [2:0] clr_v   = 3'b000;
    logic [2:0] d_v     = 3'b000;
    logic [2:0] frc_v   = 3'b000;
    logic [2:0] dff_v   = 3'b000;
    logic [2:0] q_v;

    // Reference positive-edge DFFs; frc_v inverts their output to plant a fault.
    always @(posedge clk) dff_v <= d_v;
    assign q_v = dff_v ^ frc_v;

    logic [7:0] rise_a, fall_a, errc_a, rise_b, fall_b, errc_b;
    logic [1:0] rise_c, fall_c, errc_c;
    logic       err_a, hit_a, err_b, hit_b, err_c, hit_c;
    logic [1:0] st_a, st_b, st_c;

    ff_stream_checker #(.CNT_W(8), .PAT_W(4), .PATTERN(4'b1010), .STOP_ON_ERR(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n_v[0]), .en(en_v[0]), .clr(clr_v[0]), .d(d_v[0]), .q_ff(q_v[0]),
        .rise_cnt(rise_a), .fall_cnt(fall_a), .err_cnt(errc_a), .err(err_a), .pat_hit(hit_a), .state(st_a));
    ff_stream_checker #(.CNT_W(8), .PAT_W(4), .PATTERN(4'b1010), .STOP_ON_ERR(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n_v[1]), .en(en_v[1]), .clr(clr_v[1]), .d(d_v[1]), .q_ff(q_v[1]),
        .rise_cnt(rise_b), .fall_cnt(fall_b), .err_cnt(errc_b), .err(err_b), .pat_hit(hit_b), .state(st_b));
    ff_stream_checker #(.CNT_W(2), .PAT_W(4), .PATTERN(4'b1010), .STOP_ON_ERR(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n_v[2]), .en(en_v[2]), .clr(clr_v[2]), .d(d_v[2]), .q_ff(q_v[2]),
        .rise_cnt(rise_c), .fall_cnt(fall_c), .err_cnt(errc_c), .err(err_c), .pat_hit(hit_c), .state(st_c));

    typedef struct {
        int    sel;
        int    st;
        int    rise;
        int    fall;
        int    errc;
        int    err;
        int    hit;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Apply one cycle of stimulus to instance sel and queue the expected outputs after the edge.
    task automatic step(input int sel, input bit rst, input bit en, input bit clr, input bit d,
                        input bit frc, input int st, input int rise, input int fall,
                        input int errc, input int err, input int hit, input string name);
        exp_t e;
        @(negedge clk);
        rst_n_v[sel] = rst;
        en_v[sel]    = en;
        clr_v[sel]   = clr;
        d_v[sel]     = d;
        frc_v[sel]   = frc;
        e.sel = sel; e.st = st; e.rise = rise; e.fall = fall;
        e.errc = errc; e.err = err; e.hit = hit; e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per clock, compared 1 time unit after the edge.
    initial begin
        exp_t e;
        int a_st, a_rise, a_fall, a_errc, a_err, a_hit;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.sel)
                    0: begin a_st = int'(st_a); a_rise = int'(rise_a); a_fall = int'(fall_a);
                             a_errc = int'(errc_a); a_err = int'(err_a); a_hit = int'(hit_a); end
                    1: begin a_st = int'(st_b); a_rise = int'(rise_b); a_fall = int'(fall_b);
                             a_errc = int'(errc_b); a_err = int'(err_b); a_hit = int'(hit_b); end
                    default: begin a_st = int'(st_c); a_rise = int'(rise_c); a_fall = int'(fall_c);
                             a_errc = int'(errc_c); a_err = int'(err_c); a_hit = int'(hit_c); end
                endcase
                n_chk++;
                if ((a_st !== e.st) || (a_rise !== e.rise) || (a_fall !== e.fall) ||
                    (a_errc !== e.errc) || (a_err !== e.err) || (a_hit !== e.hit)) begin
                    n_err++;
                    $display("FAIL %s (dut %0d): got st=%0d rise=%0d fall=%0d errc=%0d err=%0d hit=%0d, expected st=%0d rise=%0d fall=%0d errc=%0d err=%0d hit=%0d",
                             e.name, e.sel, a_st, a_rise, a_fall, a_errc, a_err, a_hit,
                             e.st, e.rise, e.fall, e.errc, e.err, e.hit);
                end
            end
        end
    end

    // Hard time limit in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus: sel, rst_n, en, clr, d, fault, then expected st, rise, fall, errc, err, hit.
    initial begin
        // Instance A: reset, prime, correct DFF stream d=1,1,0,1,0,0,1
        step(0, 0,1,0,1,0, 0,0,0,0,0,0, "a_rst1");
        step(0, 0,1,0,0,0, 0,0,0,0,0,0, "a_rst2");
        step(0, 0,1,0,1,0, 0,0,0,0,0,0, "a_rst3");
        step(0, 1,1,0,0,0, 1,0,0,0,0,0, "a_idle_to_prime");
        step(0, 1,1,0,0,0, 2,0,0,0,0,0, "a_prime_to_check");
        step(0, 1,1,0,1,0, 2,1,0,0,0,0, "a_seq1");
        step(0, 1,1,0,1,0, 2,1,0,0,0,0, "a_seq2");
        step(0, 1,1,0,0,0, 2,1,1,0,0,0, "a_seq3");
        step(0, 1,1,0,1,0, 2,2,1,0,0,0, "a_seq4");
        step(0, 1,1,0,0,0, 2,2,2,0,0,1, "a_seq5_hit");
        step(0, 1,1,0,0,0, 2,2,2,0,0,0, "a_seq6");
        step(0, 1,1,0,1,0, 2,3,2,0,0,0, "a_seq7");
        // Fault with STOP_ON_ERR=1, then frozen FAIL, then clr
        step(0, 1,1,0,1,1, 3,3,2,1,1,0, "a_fault_fail");
        step(0, 1,1,0,0,0, 3,3,2,1,1,0, "a_frozen1");
        step(0, 1,1,0,1,0, 3,3,2,1,1,0, "a_frozen2");
        step(0, 1,0,0,0,0, 3,3,2,1,1,0, "a_frozen_en0");
        step(0, 1,0,1,0,0, 0,0,0,0,0,0, "a_clr");
        step(0, 1,0,0,0,0, 0,0,0,0,0,0, "a_idle");
        // Pattern stream 1,0,1,0,1,0 starting at the PRIME edge
        step(0, 1,1,0,0,0, 1,0,0,0,0,0, "a_p_idle");
        step(0, 1,1,0,1,0, 2,1,0,0,0,0, "a_p_bit1");
        step(0, 1,1,0,0,0, 2,1,1,0,0,0, "a_p_bit2");
        step(0, 1,1,0,1,0, 2,2,1,0,0,0, "a_p_bit3");
        step(0, 1,1,0,0,0, 2,2,2,0,0,1, "a_p_bit4_hit");
        step(0, 1,1,0,1,0, 2,3,2,0,0,0, "a_p_bit5");
        step(0, 1,1,0,0,0, 2,3,3,0,0,1, "a_p_bit6_hit");
        step(0, 1,1,0,0,0, 2,3,3,0,0,0, "a_p_after");
        // Mid-operation clear and reset
        step(0, 1,1,1,0,0, 0,0,0,0,0,0, "a_clr_in_check");
        step(0, 1,1,0,0,0, 1,0,0,0,0,0, "a_reprime");
        step(0, 0,1,0,0,0, 0,0,0,0,0,0, "a_rst_in_prime");
        step(0, 1,0,0,0,0, 0,0,0,0,0,0, "a_idle_after_rst");

        // Instance B: STOP_ON_ERR=0, four faults, mismatch with pattern hit, en drop
        step(1, 0,0,0,0,0, 0,0,0,0,0,0, "b_rst");
        step(1, 1,1,0,0,0, 1,0,0,0,0,0, "b_idle_to_prime");
        step(1, 1,1,0,0,0, 2,0,0,0,0,0, "b_prime_to_check");
        step(1, 1,1,0,0,1, 2,0,0,1,1,0, "b_fault1");
        step(1, 1,1,0,0,0, 2,0,0,1,1,0, "b_sticky");
        step(1, 1,1,0,0,1, 2,0,0,2,1,0, "b_fault2");
        step(1, 1,1,0,0,1, 2,0,0,3,1,0, "b_fault3");
        step(1, 1,1,0,0,1, 2,0,0,4,1,0, "b_fault4");
        step(1, 1,1,0,1,0, 2,1,0,4,1,0, "b_s1");
        step(1, 1,1,0,0,0, 2,1,1,4,1,0, "b_s2");
        step(1, 1,1,0,1,0, 2,2,1,4,1,0, "b_s3");
        step(1, 1,1,0,0,1, 2,2,2,5,1,1, "b_fault_and_hit");
        step(1, 1,1,0,1,0, 2,3,2,5,1,0, "b_s5");
        step(1, 1,0,0,1,0, 0,3,2,5,1,0, "b_en_drop");
        step(1, 1,0,0,0,0, 0,3,2,5,1,0, "b_idle_no_count");
        step(1, 1,1,0,0,0, 1,3,2,5,1,0, "b_reenable");
        step(1, 1,1,0,0,0, 2,3,2,5,1,0, "b_prime_no_stale");
        step(1, 1,1,0,1,0, 2,4,2,5,1,0, "b_r1");
        step(1, 1,1,0,0,0, 2,4,3,5,1,0, "b_r2_no_stale");
        step(1, 1,1,0,1,0, 2,5,3,5,1,0, "b_r3");
        step(1, 1,1,0,0,0, 2,5,4,5,1,1, "b_r4_hit");
        step(1, 1,1,0,0,0, 2,5,4,5,1,0, "b_r5");

        // Instance C: CNT_W=2, five rising edges saturate at 3
        step(2, 0,0,0,0,0, 0,0,0,0,0,0, "c_rst");
        step(2, 1,1,0,0,0, 1,0,0,0,0,0, "c_idle_to_prime");
        step(2, 1,1,0,0,0, 2,0,0,0,0,0, "c_prime_to_check");
        step(2, 1,1,0,1,0, 2,1,0,0,0,0, "c_t1");
        step(2, 1,1,0,0,0, 2,1,1,0,0,0, "c_t2");
        step(2, 1,1,0,1,0, 2,2,1,0,0,0, "c_t3");
        step(2, 1,1,0,0,0, 2,2,2,0,0,1, "c_t4");
        step(2, 1,1,0,1,0, 2,3,2,0,0,0, "c_t5");
        step(2, 1,1,0,0,0, 2,3,3,0,0,1, "c_t6");
        step(2, 1,1,0,1,0, 2,3,3,0,0,0, "c_t7_sat_rise");
        step(2, 1,1,0,0,0, 2,3,3,0,0,1, "c_t8_sat_fall");
        step(2, 1,1,0,1,0, 2,3,3,0,0,0, "c_t9_sat_rise");

        // Drain the scoreboard with a bounded wait
        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ff_stream_checker.md
Name: ff_stream_checker

Overview:
- Synthesizable self-checking receiver for the single-bit d stream that drives our flip-flop/latch comparison benches.
- Samples d and the q output of a positive-edge D flip-flop under test on every rising clk edge.
- Verifies that q equals d delayed by exactly one cycle, counts rising and falling edges of d, and flags a programmed serial pattern.
- Sits beside the storage-element DUT in benches and on-chip debug builds, replacing waveform inspection with counters and flags.

Parameters:
- CNT_W, 8, width of rise_cnt, fall_cnt and err_cnt; all three saturate at 2^CNT_W-1.
- PAT_W, 4, length of the serial pattern detector in bits (valid range 2..16).
- PATTERN, 4'b1010, pattern to detect; MSB is the oldest sample.
- STOP_ON_ERR, 1, 1 = enter FAIL on the first mismatch; 0 = keep checking and counting.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  checking enable.
- clr  in  1  synchronous clear of counters, flags, history and FSM.
- d  in  1  stimulus bit, the same one driving the DUT.
- q_ff  in  1  output of the positive-edge DFF under test.
- rise_cnt  out  CNT_W  number of 0->1 transitions of sampled d.
- fall_cnt  out  CNT_W  number of 1->0 transitions of sampled d.
- err_cnt  out  CNT_W  number of q_ff mismatches.
- err  out  1  sticky; set on the first mismatch.
- pat_hit  out  1  one-cycle pulse on pattern match.
- state  out  2  FSM state: IDLE=0, PRIME=1, CHECK=2, FAIL=3.

Behaviour:
- Priority per edge: rst_n low > clr high > normal operation. rst_n and clr give identical results: all counters 0, err=0, pat_hit=0, history cleared, state=IDLE, internal d_q=0.
- d_q holds d sampled at the previous edge. It updates every edge in PRIME and CHECK; in IDLE it loads d.
- IDLE: outputs hold their values. When en=1, go to PRIME. No edge counting and no checking in IDLE.
- PRIME: lasts exactly one cycle, so d_q is valid. If en=1, go to CHECK; otherwise go to IDLE. Edge counting and pattern shifting start in this state. No q_ff compare here, because the DUT history is unknown.
- CHECK, compare: each edge, a mismatch is q_ff != d_q.
  - On mismatch: err_cnt += 1 (saturating) and err is set.
  - If STOP_ON_ERR=1, the next state is FAIL.
- CHECK, exit: en=0 sends the FSM to IDLE with counters held.
- FAIL: all counters, err and history are frozen and pat_hit=0. FAIL is left only by clr or rst_n; en is ignored.
- Edge counting (PRIME and CHECK only): if d=1 and d_q=0, rise_cnt += 1; if d=0 and d_q=1, fall_cnt += 1. Both counters hold at all-ones.
- Pattern detection:
  - A PAT_W-bit shift register takes d at each PRIME/CHECK edge.
  - A fill counter reaches PAT_W and then stops.
  - pat_hit is registered: it is high in the cycle after the edge that shifts in the last pattern bit, provided the fill is complete and the new register value equals PATTERN.
  - Overlapping matches are detected.
  - Entering IDLE clears the history and the fill counter.
- Simultaneous mismatch and pattern match at the same edge: both are reported.
- A mismatch at the edge that enters FAIL is counted.
- Counters are unsigned; saturation has no wrap-around.
- Mid-operation reset or clear: takes effect at the next rising edge regardless of state. Outputs equal their reset values in the following cycle.

Test Plan:
- Reset with en=1 and d toggling, then release rst_n -> state goes 0, 1, 2 on successive edges; all counters 0 and err=0 until the first CHECK edge.
- q_ff driven by a correct DFF with d=1,1,0,1,0,0,1 -> err_cnt=0, rise_cnt=3, fall_cnt=2.
- q_ff forced to 0 for one cycle while d_q=1, STOP_ON_ERR=1 -> err_cnt=1, err=1, state=3; later d toggles leave the counters frozen; clr pulse returns state to 0 with all counters 0.
- Same fault with STOP_ON_ERR=0, then three more forced faults -> err_cnt=4, state stays 2.
- d stream 1,0,1,0,1,0 with PATTERN=1010 -> pat_hit pulses exactly twice, after the 4th and 6th sampled bits.
- CNT_W=2 with 5 rising edges -> rise_cnt saturates at 3. Deasserting en mid-stream returns to IDLE; re-enabling passes through PRIME with no spurious edge count and no pattern hit from stale history.
